dht11_emulator: RTL and testbench



---
 rtl/dht11_pkg.sv | 38 +++
 rtl/dht_bus_sync.sv | 27 ++
 rtl/dht11_emulator.sv | 210 +++++++++++++++++++++
 tb/tb_dht11_emulator.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM states, default bus timing (in 1 us clock
// cycles) and the frame checksum helper used by both the emulator and the reader.
package dht11_pkg;

  localparam int DHT_START_MIN_LOW = 18000;
  localparam int DHT_RESP_DELAY    = 30;
  localparam int DHT_RESP_LOW      = 80;
  localparam int DHT_RESP_HIGH     = 80;
  localparam int DHT_BIT_LOW       = 50;
  localparam int DHT_BIT0_HIGH     = 26;
  localparam int DHT_BIT1_HIGH     = 70;
  localparam int DHT_HOLDOFF       = 200;

  // Cycles the synchronizer needs before a released bus reads back high.
  localparam int DHT_SETTLE_CYCLES = 3;
  localparam int DHT_CNT_W         = 15;
  localparam int DHT_FRAME_BITS    = 40;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_RESP_WAIT,
    ST_RESP_LO,
    ST_RESP_HI,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_END_LO,
    ST_COOLDOWN
  } dht_state_e;

  function automatic logic [7:0] dht_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
    logic [9:0] sum;
    sum = {2'b00, b0} + {2'b00, b1} + {2'b00, b2} + {2'b00, b3};
    return sum[7:0];
  endfunction

endpackage

// File: rtl/dht_bus_sync.sv
// Two-flop synchronizer for the open-drain bus; resets to 1 so an idle,
// pulled-up line never looks like a start request coming out of reset.
module dht_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic bus_in,
  output logic bus_s
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], bus_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign bus_s = sync_q[1];

endmodule

// File: rtl/dht11_emulator.sv
// DHT11 responder: detects a host start pulse on the shared bus and answers
// with the preamble and a 40-bit frame, aborting on bus contention.
module dht11_emulator
  import dht11_pkg::*;
#(
  parameter int START_MIN_LOW = DHT_START_MIN_LOW,
  parameter int RESP_DELAY    = DHT_RESP_DELAY,
  parameter int RESP_LOW      = DHT_RESP_LOW,
  parameter int RESP_HIGH     = DHT_RESP_HIGH,
  parameter int BIT_LOW       = DHT_BIT_LOW,
  parameter int BIT0_HIGH     = DHT_BIT0_HIGH,
  parameter int BIT1_HIGH     = DHT_BIT1_HIGH,
  parameter int HOLDOFF       = DHT_HOLDOFF
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        dht_data,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic       bad_crc,
  output logic       busy,
  output logic       frame_done,
  output logic       collision
);

  localparam int CW = DHT_CNT_W;

  // Phase counters run 0..N-1, so each phase compares against its length minus one.
  localparam logic [CW-1:0] P_START_MIN = CW'(START_MIN_LOW);
  localparam logic [CW-1:0] P_RESP_WAIT = CW'(RESP_DELAY - 1);
  localparam logic [CW-1:0] P_RESP_LO   = CW'(RESP_LOW - 1);
  localparam logic [CW-1:0] P_RESP_HI   = CW'(RESP_HIGH - 1);
  localparam logic [CW-1:0] P_BIT_LO    = CW'(BIT_LOW - 1);
  localparam logic [CW-1:0] P_BIT0_HI   = CW'(BIT0_HIGH - 1);
  localparam logic [CW-1:0] P_BIT1_HI   = CW'(BIT1_HIGH - 1);
  localparam logic [CW-1:0] P_HOLDOFF   = CW'(HOLDOFF - 1);
  localparam logic [CW-1:0] P_SETTLE    = CW'(DHT_SETTLE_CYCLES);
  localparam logic [5:0]    LAST_BIT    = 6'(DHT_FRAME_BITS - 1);

  dht_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [5:0]        bit_idx_q, bit_idx_d;
  logic [39:0]       frame_q, frame_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              coll_q, coll_d;

  logic              bus_s;
  logic              drive_low;
  logic [CW-1:0]     phase_max;
  logic              phase_end;
  logic              contention;

  dht_bus_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_in (dht_data),
    .bus_s  (bus_s)
  );

  // Decoded straight from the state flop so reset releases the bus immediately.
  assign drive_low = (state_q == ST_RESP_LO) || (state_q == ST_BIT_LO) || (state_q == ST_END_LO);
  assign dht_data  = drive_low ? 1'b0 : 1'bz;

  always_comb begin
    phase_max = '0;
    case (state_q)
      ST_RESP_WAIT: phase_max = P_RESP_WAIT;
      ST_RESP_LO:   phase_max = P_RESP_LO;
      ST_RESP_HI:   phase_max = P_RESP_HI;
      ST_BIT_LO:    phase_max = P_BIT_LO;
      ST_BIT_HI:    phase_max = frame_q[39] ? P_BIT1_HI : P_BIT0_HI;
      ST_END_LO:    phase_max = P_BIT_LO;
      ST_COOLDOWN:  phase_max = P_HOLDOFF;
      default:      phase_max = '0;
    endcase
  end

  assign phase_end  = (cnt_q == phase_max);
  assign contention = (cnt_q >= P_SETTLE) && !bus_s;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    coll_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus_s) begin
          state_d = ST_HOST_LOW;
          cnt_d   = CW'(1);
        end
      end

      ST_HOST_LOW: begin
        if (bus_s) begin
          cnt_d = '0;
          if (cnt_q >= P_START_MIN) begin
            state_d   = ST_RESP_WAIT;
            bit_idx_d = '0;
            busy_d    = 1'b1;
            frame_d   = {hum_int, hum_float, temp_int, temp_float,
                         dht_checksum(hum_int, hum_float, temp_int, temp_float) ^ {8{bad_crc}}};
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q < P_START_MIN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RESP_WAIT: begin
        if (!bus_s) begin
          state_d = ST_HOST_LOW;
          cnt_d   = CW'(1);
          busy_d  = 1'b0;
        end else if (phase_end) begin
          state_d = ST_RESP_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RESP_LO, ST_BIT_LO: begin
        if (phase_end) begin
          state_d = (state_q == ST_RESP_LO) ? ST_RESP_HI : ST_BIT_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RESP_HI, ST_BIT_HI: begin
        if (contention) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
          coll_d  = 1'b1;
        end else if (phase_end) begin
          cnt_d = '0;
          if (state_q == ST_RESP_HI) begin
            state_d = ST_BIT_LO;
          end else begin
            frame_d   = {frame_q[38:0], 1'b0};
            bit_idx_d = bit_idx_q + 6'd1;
            state_d   = (bit_idx_q == LAST_BIT) ? ST_END_LO : ST_BIT_LO;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_END_LO: begin
        if (phase_end) begin
          state_d = ST_COOLDOWN;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_COOLDOWN: begin
        if (phase_end) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      coll_q    <= coll_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign collision  = coll_q;

endmodule

// File: tb/tb_dht11_emulator.sv
// Bench for dht11_emulator: host-side start pulses, a cycle-level waveform
// model of the expected reply, and a pulse-width decoder recovering the frame.
`timescale 1ns/1ps
module tb_dht11_emulator;

  localparam int CLK_HALF  = 5;
  // Start threshold lowered so each start pulse costs ~2k cycles instead of ~19k.
  localparam int START_MIN = 2000;
  localparam int T_DELAY = 30, T_RLO = 80, T_RHI = 80, T_BLO = 50;
  localparam int T_B0 = 26, T_B1 = 70, T_HOLD = 200;
  localparam int SYNC_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_low = 1'b0;
  logic [7:0] hum_int = 8'h00, hum_float = 8'h00, temp_int = 8'h00, temp_float = 8'h00;
  logic bad_crc = 1'b0;
  logic busy, frame_done, collision;
  wire  dht_bus;

  pullup (dht_bus);
  assign dht_bus = host_low ? 1'b0 : 1'bz;

  always #CLK_HALF clk = ~clk;

  dht11_emulator #(.START_MIN_LOW(START_MIN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dht_data   (dht_bus),
    .hum_int    (hum_int),
    .hum_float  (hum_float),
    .temp_int   (temp_int),
    .temp_float (temp_float),
    .bad_crc    (bad_crc),
    .busy       (busy),
    .frame_done (frame_done),
    .collision  (collision)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected per-sample bus level and status outputs, one entry per clock.
  typedef struct packed {
    logic pad;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  logic idle_chk = 1'b0;

  task automatic push(input logic p, input logic b, input logic d, input int n);
    exp_t e;
    e.pad  = p;
    e.busy = b;
    e.done = d;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Reply as seen on the pad, starting with the first sample after host release.
  task automatic model_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic bad, input int limit);
    int sum;
    logic [39:0] w;
    sum = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
    if (bad) sum = sum ^ 255;
    w = {a, b, c, d, sum[7:0]};
    push(1'b1, 1'b0, 1'b0, SYNC_LAT);
    push(1'b1, 1'b1, 1'b0, T_DELAY);
    push(1'b0, 1'b1, 1'b0, T_RLO);
    push(1'b1, 1'b1, 1'b0, T_RHI);
    for (int i = 39; i >= 0; i--) begin
      push(1'b0, 1'b1, 1'b0, T_BLO);
      push(1'b1, 1'b1, 1'b0, w[i] ? T_B1 : T_B0);
    end
    push(1'b0, 1'b1, 1'b0, T_BLO);
    push(1'b1, 1'b1, 1'b1, 1);
    push(1'b1, 1'b1, 1'b0, T_HOLD - 1);
    push(1'b1, 1'b0, 1'b0, 1);
    while (exp_q.size() > limit) void'(exp_q.pop_back());
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!host_low) chk1("pad", dht_bus, e.pad);
      chk1("busy", busy, e.busy);
      chk1("frame_done", frame_done, e.done);
      chk1("collision", collision, 1'b0);
    end else if (idle_chk) begin
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_pad", dht_bus, ~host_low);
    end
  end

  // Pulse-width decoder: high runs of ~26 and ~70 are bits, anything else resyncs.
  int hi_run = 0, rx_bits = 0, rx_frames = 0, done_pulses = 0;
  logic [39:0] rx_sr = '0, rx_word = '0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_pulses++;
    if (dht_bus === 1'b1) begin
      hi_run++;
    end else begin
      if (hi_run > 0) begin
        if (hi_run >= 15 && hi_run <= 45) begin
          rx_sr = {rx_sr[38:0], 1'b0};
          rx_bits++;
        end else if (hi_run >= 55 && hi_run <= 75) begin
          rx_sr = {rx_sr[38:0], 1'b1};
          rx_bits++;
        end else begin
          rx_bits = 0;
        end
        if (rx_bits == 40) begin
          rx_word = rx_sr;
          rx_frames++;
          rx_bits = 0;
        end
      end
      hi_run = 0;
    end
  end

  task automatic host_start(input int low_cycles);
    @(negedge clk);
    #1 host_low = 1'b1;
    repeat (low_cycles) @(negedge clk);
    #1 host_low = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    #1;
    chki({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_rx(input string name, input int rx0, input int dn0, input logic [39:0] word);
    chki({name, "_rx_frames"}, rx_frames, rx0 + 1);
    chkw({name, "_rx_word"}, rx_word, word);
    chki({name, "_done_pulses"}, done_pulses, dn0 + 1);
    $display("[%0t] %s: received %h", $time, name, rx_word);
  endtask

  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input logic bad,
                           input logic [39:0] word);
    int rx0, dn0;
    rx0 = rx_frames;
    dn0 = done_pulses;
    hum_int = a; hum_float = b; temp_int = c; temp_float = d; bad_crc = bad;
    host_start(START_MIN + 100);
    model_frame(a, b, c, d, bad, 100000);
    wait_drain(name);
    check_rx(name, rx0, dn0, word);
  endtask

  initial begin
    #(2 * CLK_HALF * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int off, first, last, hr, k, cnt, rx0, dn0;

    repeat (3) @(negedge clk);
    chk1("reset_pad", dht_bus, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", frame_done, 1'b0);
    chk1("reset_collision", collision, 1'b0);
    #1 rst_n = 1'b1;
    $display("[%0t] reset released", $time);

    // Normal frame; payload change mid-frame must not reach the wire.
    rx0 = rx_frames; dn0 = done_pulses;
    hum_int = 8'h37; hum_float = 8'h00; temp_int = 8'h19; temp_float = 8'h00; bad_crc = 1'b0;
    host_start(START_MIN + 100);
    model_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 100000);
    off = 0; first = -1; last = -1; hr = 0;
    while (off < 6000 && !(first >= 0 && hr >= 150)) begin
      @(negedge clk);
      if (off == 10) hum_int = 8'hFF;
      if (dht_bus === 1'b0) begin
        if (first < 0) first = off;
        last = off;
        hr = 0;
      end else begin
        hr++;
      end
      off++;
    end
    chki("first_drive_offset", first, 32);
    chki("frame_length", last - first + 1, 3690);
    wait_drain("normal");
    check_rx("normal", rx0, dn0, 40'h37_00_19_00_50);

    run_frame("bad_crc", 8'h37, 8'h00, 8'h19, 8'h00, 1'b1, 40'h37_00_19_00_AF);
    bad_crc = 1'b0;

    // Short starts, including one cycle under the threshold, are ignored.
    idle_chk = 1'b1;
    host_start(1000);
    repeat (50) @(negedge clk);
    host_start(START_MIN - 1);
    repeat (100) @(negedge clk);
    #1 idle_chk = 1'b0;
    $display("[%0t] short starts ignored", $time);

    run_frame("boundary", 8'h01, 8'h80, 8'hFE, 8'h7F, 1'b0, 40'h01_80_FE_7F_FE);

    // Contention 10 cycles into the first BIT_HI.
    dn0 = done_pulses;
    hum_int = 8'h37; hum_float = 8'h00; temp_int = 8'h19; temp_float = 8'h00;
    host_start(START_MIN + 100);
    model_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 252);
    repeat (252) @(negedge clk);
    #1 host_low = 1'b1;
    k = 0;
    while (k < 20 && collision !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chki("collision_latency", k, 3);
    chk1("collision_busy", busy, 1'b1);
    cnt = 0;
    @(negedge clk); cnt++;
    chk1("collision_width", collision, 1'b0);
    repeat (6) begin @(negedge clk); cnt++; end
    #1 host_low = 1'b0;
    @(negedge clk); cnt++;
    chk1("collision_released", dht_bus, 1'b1);
    while (busy === 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chki("collision_busy_fall", cnt, T_HOLD);
    chki("collision_no_done", done_pulses, dn0);
    $display("[%0t] collision handled", $time);

    // Asynchronous reset while driving a BIT_LO.
    host_start(START_MIN + 100);
    model_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 280);
    repeat (280) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk1("reset_mid_pad", dht_bus, 1'b1);
    chk1("reset_mid_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    $display("[%0t] mid-frame reset", $time);
    run_frame("after_reset", 8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 40'h37_00_19_00_50);

    // A start pulse during COOLDOWN is ignored; the next one is answered.
    rx0 = rx_frames; dn0 = done_pulses;
    host_start(START_MIN + 100);
    model_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 100000);
    k = 0;
    while (k < 6000 && frame_done !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk1("b2b_done_seen", frame_done, 1'b1);
    #1 host_low = 1'b1;
    repeat (100) @(negedge clk);
    #1 host_low = 1'b0;
    wait_drain("b2b_first");
    check_rx("b2b_first", rx0, dn0, 40'h37_00_19_00_50);
    idle_chk = 1'b1;
    repeat (300) @(negedge clk);
    #1 idle_chk = 1'b0;
    run_frame("b2b_second", 8'h42, 8'h05, 8'h17, 8'h09, 1'b0, 40'h42_05_17_09_67);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
